// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared types and constants for the shift sequencer
// Holds the FSM state encoding, the direction encoding and the default widths
// used by shift_seq_ctrl, its command interface and the shift_cnt counter.
package shift_seq_ctrl_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_AW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - command/response bundle between ALU control and sequencer
// Signals:
//   start, op_dir, op_amt, op_data : command from the ALU control unit
//   busy, done, result, last_bit   : status and response from the sequencer
// Modports: master = ALU control side, slave = shift_seq_ctrl side.
interface shift_seq_ctrl_if #(
  parameter int W  = 8,
  parameter int AW = 4
) ();

  logic          start;
  logic          op_dir;
  logic [AW-1:0] op_amt;
  logic [W-1:0]  op_data;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          last_bit;

  modport master (
    output start, op_dir, op_amt, op_data,
    input  busy, done, result, last_bit
  );

  modport slave (
    input  start, op_dir, op_amt, op_data,
    output busy, done, result, last_bit
  );

endinterface

// File: rtl/shift_seq_ctrl_cnt.sv
// rtl/shift_seq_ctrl_cnt.sv - loadable shift-amount down-counter with clamp
// Module shift_cnt.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load, din  : load din, clamped to W, on the next edge
//   dec        : decrement by one on the next edge (load has priority)
//   is_zero    : count == 0
//   is_one     : count == 1 (last shift in progress)
module shift_cnt #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [AW-1:0] din,
  output logic          is_zero,
  output logic          is_one
);

  localparam logic [AW-1:0] AMT_MAX = AW'(W);

  logic [AW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (din > AMT_MAX) ? AMT_MAX : din;
    end else if (dec) begin
      count <= count - AW'(1);
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == AW'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequencer driving an 8-bit bidirectional shift register
// Accepts one shift command (data, direction, amount), loads the register,
// applies exactly N shifts, then returns the result, the last bit shifted out
// and a one-cycle done pulse.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   cmd (slave)      : start/op_dir/op_amt/op_data in; busy/done/result/last_bit out
//   sr_in, sr_load, sr_dr : drive the shift register IN/load/dr pins
//   sr_q, sr_msb, sr_lsb  : shift register outputs
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic         clk,
  input  logic         rst,
  shift_seq_ctrl_if.slave cmd,
  output logic [W-1:0] sr_in,
  output logic         sr_load,
  output logic         sr_dr,
  input  logic [W-1:0] sr_q,
  input  logic         sr_msb,
  input  logic         sr_lsb
);

  state_t       state, next_state;
  logic         dir_q;
  logic [W-1:0] data_q;
  logic [W-1:0] result_q;
  logic         last_bit_q;
  logic         done_q;
  logic         cnt_load, cnt_dec;
  logic         cnt_zero, cnt_one;
  logic         accept;

  assign accept = (state == ST_IDLE) && cmd.start;

  // The counter latches the clamped amount together with the command, so it
  // already holds N when the FSM leaves LOAD.
  shift_cnt #(.W(W), .AW(AW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .din     (cmd.op_amt),
    .is_zero (cnt_zero),
    .is_one  (cnt_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dir_q      <= 1'b0;
      data_q     <= '0;
      result_q   <= '0;
      last_bit_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state == ST_FIN);
      if (accept) begin
        dir_q      <= cmd.op_dir;
        data_q     <= cmd.op_data;
        last_bit_q <= 1'b0;
      end
      // Capture the bit about to leave before the register shifts it out.
      if (state == ST_SHIFT) begin
        last_bit_q <= (dir_q == DIR_LEFT) ? sr_msb : sr_lsb;
      end
      if (state == ST_FIN) begin
        result_q <= sr_q;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    // The register shifts whenever load is low, so every non-SHIFT state
    // holds it by reloading its own output.
    sr_load    = 1'b1;
    sr_in      = sr_q;
    sr_dr      = DIR_RIGHT;
    case (state)
      ST_IDLE: begin
        if (cmd.start) begin
          next_state = ST_LOAD;
          cnt_load   = 1'b1;
        end
      end
      ST_LOAD: begin
        sr_in      = data_q;
        next_state = cnt_zero ? ST_FIN : ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_load = 1'b0;
        sr_dr   = dir_q;
        cnt_dec = 1'b1;
        if (cnt_one) next_state = ST_FIN;
      end
      ST_FIN: begin
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign cmd.busy     = (state != ST_IDLE);
  assign cmd.done     = done_q;
  assign cmd.result   = result_q;
  assign cmd.last_bit = last_bit_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl with a shift register model
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sr_in, sr_q;
  logic       sr_load, sr_dr;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int busy_run = 0;

  typedef struct {
    logic [7:0] res;
    logic       lb;
    int         edge_at;
    int         busy_len;
  } exp_t;

  exp_t sb[$];

  shift_seq_ctrl_if #(.W(8), .AW(4)) ifc ();

  shift_seq_ctrl #(.W(8), .AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (ifc),
    .sr_in   (sr_in),
    .sr_load (sr_load),
    .sr_dr   (sr_dr),
    .sr_q    (sr_q),
    .sr_msb  (sr_q[7]),
    .sr_lsb  (sr_q[0])
  );

  // Bidirectional shift register: loads when load=1, else shifts with zero fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= 8'h00;
    else if (sr_load) sr_q <= sr_in;
    else if (sr_dr) sr_q <= {sr_q[6:0], 1'b0};
    else sr_q <= {1'b0, sr_q[7:1]};
  end

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] d, input logic dir, input int amt,
                                output logic [7:0] r, output logic lb);
    int n;
    int v;
    n = (amt > 8) ? 8 : amt;
    v = int'(d);
    if (dir) begin
      r  = 8'((v * (1 << n)) % 256);
      lb = (n == 0) ? 1'b0 : d[8-n];
    end else begin
      r  = 8'(v / (1 << n));
      lb = (n == 0) ? 1'b0 : d[n-1];
    end
  endfunction

  // Call at a negedge; returns just after the sampling edge.
  task automatic issue(input logic [7:0] d, input logic dir, input int amt, input bit accepted);
    exp_t e;
    int n;
    n = (amt > 8) ? 8 : amt;
    ifc.start   = 1'b1;
    ifc.op_data = d;
    ifc.op_dir  = dir;
    ifc.op_amt  = 4'(amt);
    if (accepted) begin
      model(d, dir, amt, e.res, e.lb);
      e.edge_at  = edge_cnt + n + 3;
      e.busy_len = n + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    ifc.start   = 1'b0;
    ifc.op_data = 8'($urandom);
    ifc.op_amt  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (ifc.busy && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (ifc.busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!ifc.done && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.done) chk("done_timeout", 1, 0);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (ifc.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", int'(ifc.result), int'(e.res));
          chk("last_bit", int'(ifc.last_bit), int'(e.lb));
          chk("done_latency", edge_cnt, e.edge_at);
          chk("busy_cycles", busy_run, e.busy_len);
        end
      end
      if (ifc.busy) busy_run++;
      else busy_run = 0;
    end
  end

  initial begin
    logic [7:0] held;
    int bad;
    ifc.start   = 1'b0;
    ifc.op_dir  = 1'b0;
    ifc.op_amt  = '0;
    ifc.op_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    chk("rst_result", int'(ifc.result), 0);
    chk("rst_last_bit", int'(ifc.last_bit), 0);
    chk("rst_sr_load", int'(sr_load), 1);
    rst = 1'b1;
    @(negedge clk);

    issue(8'hCC, 1'b0, 3, 1);
    wait_idle();

    // Second start while busy is dropped.
    issue(8'h33, 1'b1, 2, 1);
    issue(8'hFF, 1'b0, 3, 0);
    wait_idle();

    // Zero-length op: register must never shift.
    @(negedge clk);
    issue(8'hA5, 1'($urandom), 0, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sr_load) bad++;
      if (ifc.done) break;
    end
    chk("amt0_sr_load_low_cycles", bad, 0);

    wait_idle();
    issue(8'hFF, 1'b1, 12, 1);
    wait_idle();

    // Idle hold by recirculation.
    held = sr_q;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sr_q != held || !sr_load) bad++;
    end
    chk("idle_hold_errors", bad, 0);

    // Reset in the second SHIFT cycle.
    issue(8'h3C, 1'b0, 5, 1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(ifc.busy), 0);
    chk("abort_done", int'(ifc.done), 0);
    chk("abort_result", int'(ifc.result), 0);
    chk("abort_last_bit", int'(ifc.last_bit), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(8'h81, 1'b0, 1, 1);

    // Back-to-back in the done cycle, then randomized traffic.
    wait_done();
    issue(8'h96, 1'b1, 4, 1);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) wait_done();
      else wait_idle();
      issue(8'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
